uart_tx_ctrl: RTL
=================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, sysclk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_AW, default 4, FIFO address width; depth = 2**FIFO_AW.
REQ-003 SHALL have port sysclk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port cpu_resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  CPU byte-write strobe, one byte per asserted cycle.
REQ-006 SHALL have port wr_data  input  8  byte to transmit, sampled when wr_en=1.
REQ-007 SHALL have port full  output  1  FIFO holds 2**FIFO_AW entries.
REQ-008 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-009 SHALL have port count  output  FIFO_AW+1  current FIFO occupancy.
REQ-010 SHALL have port busy  output  1  high while a frame is on the line (state != IDLE).
REQ-011 SHALL have port ovf  output  1  sticky: a write was dropped because FIFO was full.
REQ-012 SHALL have port uart_tx  output  1  serial line, idle high, registered.

Function
REQ-013 SHALL accept a write when wr_en=1 and full=0 at the clock edge; byte enters FIFO tail, count+1.
REQ-014 SHALL drop a write when wr_en=1 and full=1, leaving FIFO contents unchanged and setting ovf=1; ovf clears only on reset.
REQ-015 SHALL derive full/empty/count from registered pointers only; a pop in the same cycle does not make a write legal while full=1.
REQ-016 SHALL on simultaneous accepted write and pop keep count unchanged; both pointers advance, wrapping modulo 2**FIFO_AW.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-018 SHALL in IDLE with empty=0 pop the head byte into an 8-bit shift register, clear the baud counter, and enter START the same edge; uart_tx=0 from the following cycle.
REQ-019 SHALL hold each state's bit for exactly CLKS_PER_BIT cycles, timed by a baud counter counting 0..CLKS_PER_BIT-1.
REQ-020 SHALL in START drive 0, then enter DATA.
REQ-021 SHALL in DATA drive shift-register bits LSB first, 8 bits, using a 3-bit bit index; after bit 7 enter STOP.
REQ-022 SHALL in STOP drive 1; at the end of the stop bit enter START directly (popping the next byte) when empty=0, else IDLE; back-to-back frames have no extra idle cycle.
REQ-023 SHALL make each frame exactly 10*CLKS_PER_BIT cycles of uart_tx.
REQ-024 SHALL drive uart_tx=1 in IDLE; busy=0 only in IDLE.
REQ-025 SHALL first drive uart_tx=0 two edges after an accepted write into an empty FIFO while IDLE (write edge N, pop edge N+1, line low after edge N+2).
REQ-026 SHALL ignore wr_data when wr_en=0; the FIFO never pops when empty.

Reset
REQ-027 SHALL on cpu_resetn=0 immediately (asynchronously) set state=IDLE, pointers=0, count=0, empty=1, full=0, ovf=0, busy=0, baud counter=0, bit index=0, uart_tx=1.
REQ-028 SHALL discard any frame in progress and all queued bytes on reset mid-operation; no partial frame resumes after release.
REQ-029 SHALL begin normal operation on the first rising edge after cpu_resetn deasserts.

Verification (CLKS_PER_BIT=4, FIFO_AW=4)
REQ-030 SHALL verify single byte: write 0x55 into idle block -> uart_tx low 2 edges later, then 4-cycle bits 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), busy high 40 cycles, then IDLE.
REQ-031 SHALL verify overflow: 18 consecutive writes 0x00..0x11 -> first byte popped, bytes 0x01..0x10 fill FIFO (full=1, count=16), 0x11 dropped, ovf=1; 17 frames sent back-to-back (680 cycles, no gap), empty=1 afterwards.
REQ-032 SHALL verify simultaneous write/pop: with count=1 and state at end of STOP, write on the popping edge -> count stays 1, next frame starts with no idle cycle.
REQ-033 SHALL verify reset mid-frame: assert cpu_resetn=0 during DATA bit 3 with 5 bytes queued -> uart_tx=1 before next clock edge, count=0, busy=0; after release line stays high with no writes.
REQ-034 SHALL verify wrap-around: 40 bytes written in bursts of 8 with gaps -> all 40 transmitted in order, pointers wrap, no ovf.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmitter with a CPU-side byte FIFO.
// 8N1 framing, fixed baud divider, sticky overflow flag.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 4
) (
    input  logic               sysclk,
    input  logic               cpu_resetn,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic               busy,
    output logic               ovf,
    output logic               uart_tx
);

    localparam int DEPTH = 2**FIFO_AW;
    localparam logic [15:0]        BAUD_MAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
    localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    state_t             state_q, state_d;
    logic [15:0]        baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               tx_q, tx_d;
    logic               push, pop, baud_end;

    // Flags come from registered occupancy only, so a same-cycle pop
    // never makes a write legal while full.
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign push     = wr_en && !full;
    assign baud_end = (baud_q == BAUD_MAX);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        ovf_d    = ovf_q | (wr_en & full);
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + CNT_ONE;
        else if (!push && pop)
            count_d = count_q - CNT_ONE;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                tx_d = shreg_q[bit_q];
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next frame when data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = mem[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (push)
            mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
        end
    end

    assign count   = count_q;
    assign busy    = (state_q != IDLE);
    assign ovf     = ovf_q;
    assign uart_tx = tx_q;

endmodule
